// File: rtl/cpu_clock_gen.sv
// CPU clock generator: divides clk_ula by a selectable ratio, stretches the high phase under
// contention, and tracks the T-state within each video frame to produce the Z80 frame interrupt.
module cpu_clock_gen #(
  parameter int TSTATES_PER_FRAME = 69888,
  parameter int INT_TSTATES       = 32,
  parameter int T_W               = 17
) (
  input  logic           clk_ula,
  input  logic           reset,
  input  logic [1:0]     speed,
  input  logic           contend,
  output logic           clk_cpu,
  output logic           cpu_rise,
  output logic           cpu_fall,
  output logic           stalled,
  output logic [T_W-1:0] tstate,
  output logic           frame_start,
  output logic           int_n
);

  if (INT_TSTATES == 0 || INT_TSTATES >= TSTATES_PER_FRAME ||
      (64'd1 << T_W) < 64'(TSTATES_PER_FRAME)) begin : g_param_check
    $error("cpu_clock_gen: illegal INT_TSTATES / TSTATES_PER_FRAME / T_W combination");
  end

  localparam logic [T_W-1:0] LAST_T = T_W'(TSTATES_PER_FRAME - 1);
  localparam logic [T_W-1:0] INT_T  = T_W'(INT_TSTATES);

  logic [2:0]     counter;
  logic [2:0]     reload;
  logic           hold;
  logic           toggle;
  logic           rise_now;
  logic [T_W-1:0] tstate_nxt;

  // reload is H-1, so a half-phase always lasts H clk_ula cycles
  always_comb begin
    reload = 3'd1;
    case (speed)
      2'b00:   reload = 3'd1;
      2'b01:   reload = 3'd0;
      2'b10:   reload = 3'd3;
      default: reload = 3'd7;
    endcase
  end

  assign hold       = (counter == 3'd0) && clk_cpu && contend;
  assign toggle     = (counter == 3'd0) && !hold;
  assign rise_now   = toggle && !clk_cpu;
  assign tstate_nxt = (tstate == LAST_T) ? '0 : tstate + T_W'(1);

  always_ff @(posedge clk_ula or posedge reset) begin
    if (reset) begin
      clk_cpu     <= 1'b0;
      counter     <= 3'd0;
      cpu_rise    <= 1'b0;
      cpu_fall    <= 1'b0;
      stalled     <= 1'b0;
      tstate      <= LAST_T;
      frame_start <= 1'b0;
      int_n       <= 1'b1;
    end else begin
      stalled     <= hold;
      cpu_rise    <= rise_now;
      cpu_fall    <= toggle && clk_cpu;
      frame_start <= rise_now && (tstate == LAST_T);
      if (toggle) begin
        clk_cpu <= !clk_cpu;
        counter <= reload;
      end else if (counter != 3'd0) begin
        counter <= counter - 3'd1;
      end
      // T-states advance only on rises, so a stall inside the int window lengthens int_n low
      if (rise_now) begin
        tstate <= tstate_nxt;
        if (tstate_nxt == '0)
          int_n <= 1'b0;
        else if (tstate_nxt == INT_T)
          int_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_clock_gen.sv
// Directed bench for cpu_clock_gen with a 16 T-state frame and a 3 T-state interrupt.
module tb_cpu_clock_gen;

  logic       clk_ula = 1'b0;
  logic       reset   = 1'b1;
  logic [1:0] speed   = 2'b00;
  logic       contend = 1'b0;
  logic       clk_cpu, cpu_rise, cpu_fall, stalled, frame_start, int_n;
  logic [4:0] tstate;

  int tests = 0;
  int fails = 0;

  cpu_clock_gen #(.TSTATES_PER_FRAME(16), .INT_TSTATES(3), .T_W(5)) dut (
    .clk_ula(clk_ula), .reset(reset), .speed(speed), .contend(contend),
    .clk_cpu(clk_cpu), .cpu_rise(cpu_rise), .cpu_fall(cpu_fall), .stalled(stalled),
    .tstate(tstate), .frame_start(frame_start), .int_n(int_n)
  );

  always #5 clk_ula = ~clk_ula;

  typedef struct {
    logic [1:0] speed;
    logic       contend;
    logic [3:0] exp;   // {clk_cpu, cpu_rise, cpu_fall, stalled}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] s, input logic c, input logic k, input logic r,
                     input logic f, input logic st);
    vec_t v;
    v.speed = s; v.contend = c; v.exp = {k, r, f, st};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_ula);
    #1;
  endtask

  task automatic check_reset_state(input string name);
    check(name, {27'd0, clk_cpu, cpu_rise, cpu_fall, stalled, frame_start},
          32'd0);
    check({name, "_frame"}, {26'd0, int_n, tstate}, {26'd0, 1'b1, 5'd15});
  endtask

  task automatic do_reset;
    reset   = 1'b1;
    speed   = 2'b00;
    contend = 1'b0;
    step;
    step;
    check_reset_state("reset");
    reset = 1'b0;
  endtask

  task automatic run_vec(input int i);
    speed   = vecs[i].speed;
    contend = vecs[i].contend;
    step;
    check($sformatf("vec_e%0d", i + 1), {28'd0, clk_cpu, cpu_rise, cpu_fall, stalled},
          {28'd0, vecs[i].exp});
  endtask

  initial begin
    // edges 1-10: /4 from reset release
    add(0,0, 1,1,0,0); add(0,0, 1,0,0,0); add(0,0, 0,0,1,0); add(0,0, 0,0,0,0);
    add(0,0, 1,1,0,0); add(0,0, 1,0,0,0); add(0,0, 0,0,1,0); add(0,0, 0,0,0,0);
    add(0,0, 1,1,0,0); add(0,0, 1,0,0,0);
    // edges 11-15: fall held off by contend, edge 16 releases it
    for (int i = 0; i < 5; i++) add(0,1, 1,0,0,1);
    add(0,0, 0,0,1,0);
    // contend during the low phase is ignored
    add(0,1, 0,0,0,0); add(0,1, 1,1,0,0); add(0,0, 1,0,0,0); add(0,0, 0,0,1,0);
    add(0,0, 0,0,0,0); add(0,0, 1,1,0,0);
    // switch to /2 one cycle after a rise
    add(1,0, 1,0,0,0); add(1,0, 0,0,1,0); add(1,0, 1,1,0,0); add(1,0, 0,0,1,0);
    add(1,0, 1,1,0,0);
    // switch to /16: 8-cycle phases from the next reload
    add(3,0, 0,0,1,0);
    for (int i = 0; i < 7; i++) add(3,0, 0,0,0,0);
    add(3,0, 1,1,0,0);
    for (int i = 0; i < 7; i++) add(3,0, 1,0,0,0);
    add(3,0, 0,0,1,0);

    do_reset;
    for (int i = 0; i < vecs.size(); i++) run_vec(i);

    // frame counting and interrupt, /4, no contention
    do_reset;
    for (int e = 1; e <= 140; e++) begin
      logic       fs_e, int_e;
      logic [4:0] ts_e;
      step;
      fs_e  = (e == 1) || (e == 65) || (e == 129);
      int_e = !((e <= 12) || (e >= 65 && e <= 76) || (e >= 129));
      ts_e  = 5'(((e - 1) / 4) % 16);
      check($sformatf("frame_e%0d", e), {25'd0, frame_start, int_n, tstate},
            {25'd0, fs_e, int_e, ts_e});
    end

    // contention inside the interrupt window stretches int_n low by the stall length
    do_reset;
    for (int e = 1; e <= 20; e++) begin
      logic [4:0] ts_e;
      contend = (e >= 3 && e <= 6);
      step;
      ts_e = (e < 9) ? 5'd0 : (e < 13) ? 5'd1 : (e < 17) ? 5'd2 : 5'd3;
      check($sformatf("int_stall_e%0d", e), {25'd0, stalled, int_n, tstate},
            {25'd0, (e >= 3 && e <= 6), (e > 16), ts_e});
    end
    contend = 1'b0;

    // async reset in the middle of a high phase
    do_reset;
    run_vec(0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    step;
    check_reset_state("async_reset_held");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) run_vec(i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_clock_gen.md
Name: cpu_clock_gen

Overview:
- Parametrised CPU clock generator for the ULA.
- Divides clk_ula (14 MHz) by a run-time selectable ratio to produce clk_cpu, plus one-cycle rise/fall strobes for logic that runs on clk_ula.
- Supports ULA contention by stretching clk_cpu's high phase on request.
- Keeps a T-state counter per video frame and generates the frame interrupt (int_n) for the Z80.

Parameters:
- TSTATES_PER_FRAME, 69888: T-states (clk_cpu rising edges) per frame.
- INT_TSTATES, 32: length of int_n low pulse, in T-states.
- T_W, 17: width of tstate output. Must satisfy 2^T_W >= TSTATES_PER_FRAME.

Ports:
- clk_ula  in  1  ULA master clock, 14 MHz. Every flop is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- speed  in  2  divide select. 00 = /4 (3.5 MHz), 01 = /2, 10 = /8, 11 = /16.
- contend  in  1  request to hold clk_cpu high (contention stall).
- clk_cpu  out  1  registered divided CPU clock.
- cpu_rise  out  1  high for one clk_ula cycle: the first cycle in which clk_cpu reads 1.
- cpu_fall  out  1  high for one clk_ula cycle: the first cycle in which clk_cpu reads 0.
- stalled  out  1  high while a pending fall is being held off by contend.
- tstate  out  T_W  current T-state index within the frame.
- frame_start  out  1  high for one clk_ula cycle when tstate becomes 0.
- int_n  out  1  active-low Z80 interrupt.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-phase):
  - clk_cpu=0, counter=0, cpu_rise=0, cpu_fall=0, stalled=0.
  - tstate=TSTATES_PER_FRAME-1, frame_start=0, int_n=1.
  - A truncated clk_cpu phase caused by reset is acceptable.
- Half-period H, in clk_ula cycles, by speed: 00→2, 01→1, 10→4, 11→8. Internal down-counter is 3 bits.
- Each clk_ula edge:
  - If counter!=0: counter decrements. No toggle.
  - If counter==0 and (clk_cpu==0 or contend==0): clk_cpu toggles and counter loads H-1, using speed sampled on this edge.
  - If counter==0, clk_cpu==1 and contend==1: no toggle, counter stays 0, stalled=1.
- speed is used only at reload. A change takes effect at the next half-period; no half-phase is ever shorter than 1 cycle or corrupted.
- contend is ignored during the low phase and while counter!=0. Only falling edges are deferred. Stall length is unbounded.
- stalled: registered. It is 1 on each edge where the hold condition is true, and 0 otherwise.
- First rise occurs on the first clk_ula edge after reset deasserts.
- cpu_rise / cpu_fall are registered on the same edge that updates clk_cpu. They never assert together.
- tstate update, on each edge where clk_cpu goes 0→1:
  - If tstate==TSTATES_PER_FRAME-1: tstate becomes 0 and frame_start=1 for that cycle.
  - Otherwise: tstate+1.
  - Consequence: the first rise after reset starts frame 0 with a frame_start pulse.
- int_n:
  - Driven 0 on the edge where tstate becomes 0.
  - Driven 1 on the edge where tstate becomes INT_TSTATES.
  - Otherwise holds its value.
  - Low duration = INT_TSTATES T-states, stretched by any contention in that window.
- Elaboration check: error if INT_TSTATES == 0, if INT_TSTATES >= TSTATES_PER_FRAME, or if T_W is too small.

Test Plan:
- Reset release, speed=00, contend=0 → clk_cpu rises on edge 1, then a 4-cycle period at 50% duty. cpu_rise pulses at edges 1,5,9…; cpu_fall at 3,7,11…
- speed 00→01 asserted one cycle after a rise → current high phase completes (2 cycles), then 1-cycle phases with a period of 2. Repeat 01→11 → after the current phase, 8-cycle phases. No runt phase.
- contend=1 for 5 cycles, starting at the edge where the fall is due (clk_cpu=1, counter=0) → clk_cpu held high, stalled=1 for 5 edges, fall on the first edge with contend=0. contend pulsed during a low phase → timing unchanged, stalled stays 0.
- TSTATES_PER_FRAME=16, INT_TSTATES=3, speed=00 → frame_start on rise 1, 17, 33 (clk_ula edges 1, 65, 129). int_n low for exactly 12 clk_ula cycles per frame. tstate wraps 15→0.
- Contention inside the int window (same params) → int_n low time extended by exactly the stall cycles. tstate does not advance during the stall.
- Async reset asserted mid high phase, between clk_ula edges → all outputs return to reset values without waiting for an edge. After release, behaviour repeats scenario 1 exactly.
